// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download protocol: bus widths, index codes
// and the sender state encoding.
package ioctl_pkg;

   localparam int IOCTL_ADDR_W  = 25;
   localparam int IOCTL_DATA_W  = 8;
   localparam int IOCTL_INDEX_W = 8;

   localparam logic [IOCTL_INDEX_W-1:0] IOCTL_IDX_ROM = 8'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_FETCH,
      ST_WRITE,
      ST_GAP,
      ST_TAIL
   } ioctl_state_t;

endpackage

// File: rtl/ioctl_sender_if.sv
// Byte source, transfer control and ioctl download bus seen by ioctl_sender.
// master = the sender side, slave = the source/sink side.
interface ioctl_sender_if;
   import ioctl_pkg::*;

   logic                     start;
   logic [IOCTL_INDEX_W-1:0] index;
   logic [IOCTL_ADDR_W-1:0]  length;
   logic                     src_valid;
   logic [IOCTL_DATA_W-1:0]  src_data;
   logic                     src_ready;
   logic                     ioctl_download;
   logic                     ioctl_wr;
   logic [IOCTL_ADDR_W-1:0]  ioctl_addr;
   logic [IOCTL_DATA_W-1:0]  ioctl_dout;
   logic [IOCTL_INDEX_W-1:0] ioctl_index;
   logic                     ioctl_wait;
   logic                     busy;
   logic                     done;

   modport master (
      input  start, index, length, src_valid, src_data, ioctl_wait,
      output src_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
             ioctl_index, busy, done
   );

   modport slave (
      output start, index, length, src_valid, src_data, ioctl_wait,
      input  src_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
             ioctl_index, busy, done
   );

endinterface

// File: rtl/ioctl_sender.sv
// Pushes a byte stream onto the ioctl download bus (transmitting end of the loader).
// Optional running 16-bit byte sum on `checksum` when IOCTL_SENDER_CHECKSUM_EN is defined.
module ioctl_sender
   import ioctl_pkg::*;
#(
   parameter int SETUP_CYC = 4,
   parameter int TAIL_CYC  = 4,
   parameter int WR_GAP    = 3
) (
   input  logic           clk_sys,
   input  logic           reset_n,
   ioctl_sender_if.master bus
`ifdef IOCTL_SENDER_CHECKSUM_EN
   ,
   output logic [15:0]    checksum
`endif
);

   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
   localparam logic [7:0] TAIL_LAST  = 8'(TAIL_CYC - 1);
   localparam logic [7:0] GAP_LAST   = 8'(WR_GAP - 1);

   ioctl_state_t             state;
   ioctl_state_t             state_nxt;
   logic [7:0]               cnt;
   logic [IOCTL_ADDR_W-1:0]  remaining;
   logic [IOCTL_ADDR_W-1:0]  addr_q;
   logic [IOCTL_DATA_W-1:0]  dout_q;
   logic [IOCTL_INDEX_W-1:0] index_q;
   logic                     done_q;

   logic load;
   logic take;
   logic cnt_inc;
   logic cnt_clr;
   logic addr_inc;
   logic finish;
   logic more;

   assign more = (remaining != '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first; a path that skips
   // an assignment would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      take      = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      addr_inc  = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt == SETUP_LAST) begin
               cnt_clr   = 1'b1;
               state_nxt = more ? ST_FETCH : ST_TAIL;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_FETCH: begin
            if (bus.src_valid && !bus.ioctl_wait) begin
               take      = 1'b1;
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: state_nxt = ST_GAP;
         ST_GAP: begin
            // The gap only counts cycles the sink is not stalling.
            if (!bus.ioctl_wait) begin
               if (cnt == GAP_LAST) begin
                  cnt_clr   = 1'b1;
                  addr_inc  = 1'b1;
                  state_nxt = more ? ST_FETCH : ST_TAIL;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         ST_TAIL: begin
            if (cnt == TAIL_LAST) begin
               cnt_clr   = 1'b1;
               finish    = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         remaining <= '0;
         addr_q    <= '0;
         dout_q    <= '0;
         index_q   <= IOCTL_IDX_ROM;
         done_q    <= 1'b0;
      end else begin
         done_q <= finish;
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 8'd1;
         if (load) begin
            remaining <= bus.length;
            index_q   <= bus.index;
            addr_q    <= '0;
         end else begin
            if (take)     remaining <= remaining - 1'b1;
            if (addr_inc) addr_q    <= addr_q + 1'b1;
         end
         if (take) dout_q <= bus.src_data;
      end
   end

`ifdef IOCTL_SENDER_CHECKSUM_EN
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)              checksum <= '0;
      else if (load)             checksum <= '0;
      else if (state == ST_WRITE) checksum <= checksum + {8'h00, dout_q};
   end
`endif

   // Window and strobes decode straight from the registered state so an
   // asynchronous reset clears them without waiting for a clock.
   assign bus.src_ready      = (state == ST_FETCH) && !bus.ioctl_wait;
   assign bus.ioctl_download = (state != ST_IDLE);
   assign bus.busy           = (state != ST_IDLE);
   assign bus.ioctl_wr       = (state == ST_WRITE);
   assign bus.ioctl_addr     = addr_q;
   assign bus.ioctl_dout     = dout_q;
   assign bus.ioctl_index    = index_q;
   assign bus.done           = done_q;

endmodule

// File: tb/tb_ioctl_sender.sv
// Scoreboard bench for ioctl_sender: expected writes are queued with the source
// bytes and matched against every ioctl_wr strobe.
`timescale 1ns/1ps
module tb_ioctl_sender;
   import ioctl_pkg::*;

   localparam int SETUP_CYC = 4;
   localparam int TAIL_CYC  = 4;
   localparam int WR_GAP    = 3;

   typedef struct {
      logic [IOCTL_ADDR_W-1:0]  addr;
      logic [IOCTL_DATA_W-1:0]  data;
      logic [IOCTL_INDEX_W-1:0] idx;
   } exp_t;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   ioctl_sender_if bus ();
`ifdef IOCTL_SENDER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   ioctl_sender #(
      .SETUP_CYC(SETUP_CYC),
      .TAIL_CYC (TAIL_CYC),
      .WR_GAP   (WR_GAP)
   ) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef IOCTL_SENDER_CHECKSUM_EN
      ,
      .checksum(checksum)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   int         vectors    = 0;
   int         miscompares = 0;
   int         cyc        = 0;
   exp_t       exp_q[$];
   logic [7:0] src_q[$];
   logic       src_en     = 1'b0;
   int         wr_cnt     = 0;
   int         done_cnt   = 0;
   int         dl_cnt     = 0;
   int         done_cyc   = 0;
   int         wr_cyc[$];
   logic       wait_prev  = 1'b0;
   logic [15:0] chk_model = '0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic src_update();
      bus.src_valid = src_en && (src_q.size() != 0);
      bus.src_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
   endtask

   // Source model: a byte leaves the queue just after the edge that accepted it.
   always @(negedge clk_sys) begin
      if (reset_n && bus.src_valid && bus.src_ready) begin
         @(posedge clk_sys);
         #1;
         if (src_q.size() != 0) void'(src_q.pop_front());
         src_update();
      end
   end

   always @(negedge clk_sys) begin
      exp_t e;
      if (reset_n) begin
         if (bus.ioctl_wr === 1'b1) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            vectors++;
            if (wait_prev !== 1'b0) begin
               miscompares++;
               $display("FAIL wr_after_wait: ioctl_wr at cycle %0d, ioctl_wait previous cycle=%b, required 0",
                        cyc, wait_prev);
            end
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_wr: got addr=%h data=%h, required no write",
                        bus.ioctl_addr, bus.ioctl_dout);
            end else begin
               e = exp_q.pop_front();
               if (bus.ioctl_addr !== e.addr || bus.ioctl_dout !== e.data ||
                   bus.ioctl_index !== e.idx) begin
                  miscompares++;
                  $display("FAIL write: got addr=%h data=%h index=%h, required addr=%h data=%h index=%h",
                           bus.ioctl_addr, bus.ioctl_dout, bus.ioctl_index, e.addr, e.data, e.idx);
               end
            end
         end
         if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.ioctl_download === 1'b1) dl_cnt++;
      end
      wait_prev = bus.ioctl_wait;
   end

   task automatic clear_stats();
      wr_cnt    = 0;
      done_cnt  = 0;
      dl_cnt    = 0;
      done_cyc  = 0;
      chk_model = '0;
      wr_cyc.delete();
   endtask

   task automatic push_byte(input logic [IOCTL_ADDR_W-1:0] addr, input logic [7:0] data,
                            input logic [7:0] idx);
      exp_t e;
      e.addr = addr;
      e.data = data;
      e.idx  = idx;
      src_q.push_back(data);
      exp_q.push_back(e);
      chk_model = chk_model + {8'h00, data};
      src_update();
   endtask

   task automatic do_start(input logic [7:0] idx, input logic [IOCTL_ADDR_W-1:0] len);
      @(posedge clk_sys); #1;
      bus.index  = idx;
      bus.length = len;
      bus.start  = 1'b1;
      @(posedge clk_sys); #1;
      bus.start  = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (bus.done !== 1'b1 && n < budget);
      vectors++;
      if (bus.done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_done_timeout: done not seen in %0d cycles, required a done pulse", name, budget);
      end
      @(posedge clk_sys); #1;
   endtask

   task automatic wait_wr(input string name, input int budget);
      int n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (bus.ioctl_wr !== 1'b1 && n < budget);
      vectors++;
      if (bus.ioctl_wr !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_wr_timeout: ioctl_wr not seen in %0d cycles, required a strobe", name, budget);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      reset_n        = 1'b0;
      bus.start      = 1'b0;
      bus.index      = '0;
      bus.length     = '0;
      bus.ioctl_wait = 1'b0;
      src_en         = 1'b0;
      src_update();
      repeat (3) @(negedge clk_sys);
      vectors++;
      if ({bus.src_ready, bus.ioctl_download, bus.ioctl_wr, bus.ioctl_addr, bus.ioctl_dout,
           bus.ioctl_index, bus.busy, bus.done} !== '0) begin
         miscompares++;
         $display("FAIL reset_values: rdy=%b dl=%b wr=%b addr=%h dout=%h idx=%h busy=%b done=%b, required all 0",
                  bus.src_ready, bus.ioctl_download, bus.ioctl_wr, bus.ioctl_addr, bus.ioctl_dout,
                  bus.ioctl_index, bus.busy, bus.done);
      end
`ifdef IOCTL_SENDER_CHECKSUM_EN
      check_int("reset_checksum", int'(checksum), 0);
`endif
      @(posedge clk_sys); #1;
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      check_int("idle_busy", int'(bus.busy), 0);
   endtask

   task automatic test_basic();
      int k = 0;
      clear_stats();
      src_en = 1'b1;
      for (int i = 0; i < 4; i++) push_byte(25'(i), 8'(8'h11 * (i + 1)), 8'h00);
      do_start(8'h00, 25'd4);
      do begin
         @(negedge clk_sys);
         k++;
         if (k == 1) check_int("start_busy_dl", int'({bus.busy, bus.ioctl_download}), 3);
      end while (bus.src_ready !== 1'b1 && k < 50);
      check_int("first_ready_cycle", k, SETUP_CYC + 1);
      wait_done("basic", 400);
      check_int("basic_wr_count", wr_cnt, 4);
      for (int i = 1; i < wr_cyc.size(); i++)
         check_int("basic_wr_spacing", wr_cyc[i] - wr_cyc[i-1], WR_GAP + 2);
      if (wr_cyc.size() != 0)
         check_int("basic_done_latency", done_cyc - wr_cyc[wr_cyc.size()-1], WR_GAP + TAIL_CYC + 1);
      check_int("basic_dl_cycles", dl_cnt, SETUP_CYC + 4 * (WR_GAP + 2) + TAIL_CYC);
      check_int("basic_sb_empty", exp_q.size(), 0);
      repeat (3) @(negedge clk_sys);
      check_int("basic_done_count", done_cnt, 1);
      check_int("basic_idle", int'({bus.busy, bus.ioctl_download}), 0);
      check_int("basic_index_held", int'(bus.ioctl_index), 0);
`ifdef IOCTL_SENDER_CHECKSUM_EN
      check_int("basic_checksum", int'(checksum), int'(chk_model));
`endif
   endtask

   task automatic test_length0();
      clear_stats();
      do_start(8'h02, 25'd0);
      wait_done("len0", 100);
      repeat (3) @(negedge clk_sys);
      check_int("len0_dl_cycles", dl_cnt, SETUP_CYC + TAIL_CYC);
      check_int("len0_wr_count", wr_cnt, 0);
      check_int("len0_done_count", done_cnt, 1);
      check_int("len0_index", int'(bus.ioctl_index), 2);
   endtask

   task automatic test_wait();
      clear_stats();
      push_byte(25'd0, 8'hA5, 8'h01);
      push_byte(25'd1, 8'h5A, 8'h01);
      do_start(8'h01, 25'd2);
      wait_wr("wait", 100);
      @(posedge clk_sys); #1;
      bus.ioctl_wait = 1'b1;
      repeat (10) @(posedge clk_sys);
      #1;
      bus.ioctl_wait = 1'b0;
      wait_done("wait", 200);
      check_int("wait_wr_count", wr_cnt, 2);
      if (wr_cyc.size() == 2)
         check_int("wait_wr_spacing", wr_cyc[1] - wr_cyc[0], WR_GAP + 2 + 10);
      check_int("wait_sb_empty", exp_q.size(), 0);
   endtask

   task automatic test_src_stall();
      clear_stats();
      for (int i = 0; i < 3; i++) push_byte(25'(i), 8'(8'hC0 + i), 8'h00);
      do_start(8'h00, 25'd3);
      wait_wr("stall", 100);
      @(posedge clk_sys); #1;
      src_en = 1'b0;
      src_update();
      repeat (19) @(posedge clk_sys);
      @(negedge clk_sys);
      check_int("stall_ready_held", int'(bus.src_ready), 1);
      check_int("stall_addr", int'(bus.ioctl_addr), 1);
      check_int("stall_no_wr", wr_cnt, 1);
      // One cycle of sink wait in FETCH must hold off the handshake.
      @(posedge clk_sys); #1;
      src_en         = 1'b1;
      bus.ioctl_wait = 1'b1;
      src_update();
      @(negedge clk_sys);
      check_int("fetch_wait_ready", int'(bus.src_ready), 0);
      @(posedge clk_sys); #1;
      bus.ioctl_wait = 1'b0;
      wait_done("stall", 200);
      check_int("stall_wr_count", wr_cnt, 3);
      if (wr_cyc.size() >= 2)
         check_int("stall_wr_spacing", wr_cyc[1] - wr_cyc[0], 23);
      check_int("stall_sb_empty", exp_q.size(), 0);
   endtask

   task automatic test_reset_mid();
      clear_stats();
      for (int i = 0; i < 8; i++) push_byte(25'(i), 8'(8'h30 + i), 8'h00);
      do_start(8'h00, 25'd8);
      wait_wr("rst1", 100);
      wait_wr("rst2", 100);
      @(posedge clk_sys); #1;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({bus.src_ready, bus.ioctl_download, bus.ioctl_wr, bus.ioctl_addr, bus.ioctl_dout,
           bus.ioctl_index, bus.busy, bus.done} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: dl=%b busy=%b addr=%h dout=%h, required all outputs 0",
                  bus.ioctl_download, bus.busy, bus.ioctl_addr, bus.ioctl_dout);
      end
      exp_q.delete();
      src_q.delete();
      src_update();
      @(posedge clk_sys); #1;
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      check_int("rst_no_done", done_cnt, 0);
      check_int("rst_idle", int'(bus.busy), 0);
      clear_stats();
      push_byte(25'd0, 8'h77, 8'h03);
      push_byte(25'd1, 8'h88, 8'h03);
      do_start(8'h03, 25'd2);
      wait_done("rst_restart", 200);
      check_int("rst_restart_wr", wr_cnt, 2);
      check_int("rst_restart_sb", exp_q.size(), 0);
      check_int("rst_restart_index", int'(bus.ioctl_index), 3);
   endtask

   task automatic test_start_ignored();
      clear_stats();
      for (int i = 0; i < 3; i++) push_byte(25'(i), 8'(8'h50 + i), 8'h00);
      do_start(8'h00, 25'd3);
      wait_wr("ign", 100);
      @(posedge clk_sys); #1;
      bus.index  = 8'h05;
      bus.length = 25'd7;
      bus.start  = 1'b1;
      @(posedge clk_sys); #1;
      bus.start  = 1'b0;
      wait_done("ign", 200);
      repeat (4) @(negedge clk_sys);
      check_int("ign_wr_count", wr_cnt, 3);
      check_int("ign_done_count", done_cnt, 1);
      check_int("ign_index", int'(bus.ioctl_index), 0);
      check_int("ign_idle", int'(bus.busy), 0);
      check_int("ign_sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_length0();
      test_wait();
      test_src_stall();
      test_reset_mid();
      test_start_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
